// File: rtl/inst_pc_gen_if.sv
// Bus between the PC generator and the fetch stage. The generator drives the
// PC, valid and pipe controls; the fetch/control side drives the rest.
interface inst_pc_gen_if #(
  parameter int unsigned CNT_WIDTH = 32
);
  logic                 STALL_IN;
  logic                 MEM_WAIT;
  logic                 BRANCH_EN;
  logic [31:0]          BRANCH_PC;
  logic                 HALT_REQ;
  logic                 RESUME;
  logic [31:0]          P_PC;
  logic                 P_VALID;
  logic                 STALL;
  logic                 FLUSH;
  logic                 HALTED;
  logic                 MISALIGN;
  logic [CNT_WIDTH-1:0] ISSUE_CNT;

  modport master (
    input  STALL_IN, MEM_WAIT, BRANCH_EN, BRANCH_PC, HALT_REQ, RESUME,
    output P_PC, P_VALID, STALL, FLUSH, HALTED, MISALIGN, ISSUE_CNT
  );

  modport slave (
    output STALL_IN, MEM_WAIT, BRANCH_EN, BRANCH_PC, HALT_REQ, RESUME,
    input  P_PC, P_VALID, STALL, FLUSH, HALTED, MISALIGN, ISSUE_CNT
  );
endinterface

// File: rtl/inst_pc_gen.sv
// Program-counter generator feeding the fetch stage: sequential advance,
// redirects (deferred while fetch loads a page), and halt/resume.
module inst_pc_gen #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned CNT_WIDTH = 32
) (
  input logic           CLK,
  input logic           RST,
  inst_pc_gen_if.master pc_bus
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_HALT
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [31:0]          r_pc;
  logic [31:0]          r_pend_pc;
  logic                 r_pend_valid;
  logic                 r_halt_pend;
  logic                 r_misalign;
  logic [CNT_WIDTH-1:0] r_cnt;

  logic                 w_run;
  logic                 w_apply;
  logic [31:0]          w_target;
  logic                 w_halt_go;
  logic                 w_advance;

  always_comb begin
    w_run     = (r_state == S_RUN);
    w_apply   = !RST && !pc_bus.MEM_WAIT && (pc_bus.BRANCH_EN || r_pend_valid);
    w_target  = pc_bus.BRANCH_EN ? pc_bus.BRANCH_PC : r_pend_pc;
    w_halt_go = w_run && !pc_bus.MEM_WAIT && (pc_bus.HALT_REQ || r_halt_pend);
    // The halting PC is not consumed, so a halt suppresses the advance and
    // resume refetches the same address.
    w_advance = w_run && !pc_bus.STALL_IN && !pc_bus.MEM_WAIT && !w_apply && !w_halt_go;

    w_state_nxt = r_state;
    case (r_state)
      S_BOOT:  w_state_nxt = S_RUN;
      S_RUN:   if (w_halt_go) w_state_nxt = S_HALT;
      S_HALT:  if (pc_bus.RESUME) w_state_nxt = S_RUN;
      default: w_state_nxt = S_BOOT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= S_BOOT;
      r_pc         <= RESET_PC;
      r_pend_pc    <= '0;
      r_pend_valid <= 1'b0;
      r_halt_pend  <= 1'b0;
      r_misalign   <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_apply) begin
        r_pc         <= {w_target[31:2], 2'b00};
        r_pend_valid <= 1'b0;
        if (|w_target[1:0]) r_misalign <= 1'b1;
      end else if (w_advance) begin
        r_pc  <= r_pc + 32'd4;
        r_cnt <= r_cnt + CNT_WIDTH'(1);
      end

      // Capture during a page load; the latest target wins.
      if (pc_bus.BRANCH_EN && pc_bus.MEM_WAIT) begin
        r_pend_pc    <= pc_bus.BRANCH_PC;
        r_pend_valid <= 1'b1;
      end

      if (w_halt_go)
        r_halt_pend <= 1'b0;
      else if (w_run && pc_bus.HALT_REQ && pc_bus.MEM_WAIT)
        r_halt_pend <= 1'b1;
    end
  end

  assign pc_bus.P_PC      = r_pc;
  assign pc_bus.P_VALID   = (r_state == S_RUN);
  assign pc_bus.STALL     = !RST && pc_bus.STALL_IN && !w_apply;
  assign pc_bus.FLUSH     = w_apply;
  assign pc_bus.HALTED    = (r_state == S_HALT);
  assign pc_bus.MISALIGN  = r_misalign;
  assign pc_bus.ISSUE_CNT = r_cnt;

endmodule

// File: tb/tb_inst_pc_gen.sv
// Bench for inst_pc_gen: directed scenarios with literal expectations, then
// random traffic checked every cycle against a behavioural model.
module tb_inst_pc_gen;

  logic CLK;
  logic RST;
  int   checks = 0;
  int   errors = 0;

  inst_pc_gen_if #(.CNT_WIDTH(32)) bus ();

  inst_pc_gen #(
    .RESET_PC (32'h0000_0100),
    .CNT_WIDTH(32)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .pc_bus(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge; return mid-cycle.
  task automatic drv(input bit rst, input bit st, input bit mw, input bit br,
                     input logic [31:0] bpc, input bit hr, input bit rs);
    @(posedge CLK);
    #1;
    RST           = rst;
    bus.STALL_IN  = st;
    bus.MEM_WAIT  = mw;
    bus.BRANCH_EN = br;
    bus.BRANCH_PC = bpc;
    bus.HALT_REQ  = hr;
    bus.RESUME    = rs;
    #2;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 32'h0, 0, 0);
  endtask

  // Behavioural model: what fetch should see, updated once per clock.
  logic [31:0] m_pc       = 32'h0000_0100;
  logic [31:0] m_pend     = 32'h0;
  logic [31:0] m_cnt      = 32'h0;
  bit          m_pend_v   = 0;
  bit          m_booting  = 1;
  bit          m_halted   = 0;
  bit          m_halt_pnd = 0;
  bit          m_mis      = 0;

  always @(negedge CLK) begin
    bit          running, redirect, halt_now, step;
    logic [31:0] tgt;
    running  = !m_booting && !m_halted;
    redirect = !RST && !bus.MEM_WAIT && (bus.BRANCH_EN || m_pend_v);
    tgt      = bus.BRANCH_EN ? bus.BRANCH_PC : m_pend;
    halt_now = running && !bus.MEM_WAIT && (bus.HALT_REQ || m_halt_pnd);
    step     = running && !bus.STALL_IN && !bus.MEM_WAIT && !redirect && !halt_now;

    chk("m_P_PC",      bus.P_PC,            m_pc);
    chk("m_P_VALID",   32'(bus.P_VALID),    32'(running));
    chk("m_HALTED",    32'(bus.HALTED),     32'(m_halted));
    chk("m_MISALIGN",  32'(bus.MISALIGN),   32'(m_mis));
    chk("m_ISSUE_CNT", bus.ISSUE_CNT,       m_cnt);
    chk("m_FLUSH",     32'(bus.FLUSH),      32'(redirect));
    chk("m_STALL",     32'(bus.STALL),      32'(!RST && bus.STALL_IN && !redirect));

    if (RST) begin
      m_pc = 32'h100; m_pend = 0; m_cnt = 0; m_pend_v = 0;
      m_booting = 1; m_halted = 0; m_halt_pnd = 0; m_mis = 0;
    end else begin
      if (redirect) begin
        m_pc     = tgt & ~32'd3;
        m_mis    = m_mis || (tgt % 4 != 0);
        m_pend_v = 0;
      end else if (step) begin
        m_pc  = m_pc + 4;
        m_cnt = m_cnt + 1;
      end
      if (bus.BRANCH_EN && bus.MEM_WAIT) begin
        m_pend   = bus.BRANCH_PC;
        m_pend_v = 1;
      end
      if (m_booting) m_booting = 0;
      else if (halt_now) begin m_halted = 1; m_halt_pnd = 0; end
      else if (running && bus.HALT_REQ && bus.MEM_WAIT) m_halt_pnd = 1;
      else if (m_halted && bus.RESUME) m_halted = 0;
    end
  end

  initial begin
    int mw_left;
    int rst_left;
    RST = 1'b1;
    bus.STALL_IN = 0; bus.MEM_WAIT = 0; bus.BRANCH_EN = 0;
    bus.BRANCH_PC = 0; bus.HALT_REQ = 0; bus.RESUME = 0;

    drv(1, 0, 0, 0, 32'h0, 0, 0);
    drv(1, 0, 0, 0, 32'h0, 0, 0);
    chk("rst_P_PC", bus.P_PC, 32'h100);
    chk("rst_P_VALID", 32'(bus.P_VALID), 32'd0);
    chk("rst_STALL", 32'(bus.STALL), 32'd0);
    chk("rst_FLUSH", 32'(bus.FLUSH), 32'd0);
    chk("rst_HALTED", 32'(bus.HALTED), 32'd0);
    chk("rst_MISALIGN", 32'(bus.MISALIGN), 32'd0);
    chk("rst_ISSUE_CNT", bus.ISSUE_CNT, 32'd0);

    idle();
    chk("boot_P_VALID", 32'(bus.P_VALID), 32'd0);
    idle();
    chk("run_P_VALID", 32'(bus.P_VALID), 32'd1);
    chk("run_P_PC0", bus.P_PC, 32'h100);
    for (int i = 1; i <= 2; i++) begin
      idle();
      chk("seq_P_PC", bus.P_PC, 32'h100 + 32'(4 * i));
      chk("seq_CNT", bus.ISSUE_CNT, 32'(i));
    end

    drv(0, 0, 0, 1, 32'h20, 0, 0);
    chk("seq_P_PC3", bus.P_PC, 32'h10C);
    chk("seq_CNT3", bus.ISSUE_CNT, 32'd3);
    chk("br_FLUSH", 32'(bus.FLUSH), 32'd1);

    for (int i = 0; i < 3; i++) begin
      drv(0, 1, 0, 0, 32'h0, 0, 0);
      chk("stall_P_PC", bus.P_PC, 32'h20);
      chk("stall_STALL", 32'(bus.STALL), 32'd1);
      chk("stall_CNT", bus.ISSUE_CNT, 32'd3);
    end
    idle();
    chk("unstall_P_PC", bus.P_PC, 32'h20);

    drv(0, 1, 0, 1, 32'h400, 0, 0);
    chk("resume_P_PC", bus.P_PC, 32'h24);
    chk("resume_CNT", bus.ISSUE_CNT, 32'd4);
    chk("brstall_FLUSH", 32'(bus.FLUSH), 32'd1);
    chk("brstall_STALL", 32'(bus.STALL), 32'd0);
    idle();
    chk("brstall_P_PC", bus.P_PC, 32'h400);

    for (int w = 0; w < 10; w++) begin
      drv(0, 0, 1, (w == 2 || w == 4), (w == 2) ? 32'h800 : 32'hC00, 0, 0);
      chk("miss_P_PC", bus.P_PC, 32'h404);
      chk("miss_FLUSH", 32'(bus.FLUSH), 32'd0);
    end
    idle();
    chk("missend_FLUSH", 32'(bus.FLUSH), 32'd1);
    chk("missend_P_PC", bus.P_PC, 32'h404);
    idle();
    chk("pend_P_PC", bus.P_PC, 32'hC00);
    chk("pend_CNT", bus.ISSUE_CNT, 32'd5);

    drv(0, 0, 0, 1, 32'h1002, 0, 0);
    chk("mis_before", 32'(bus.MISALIGN), 32'd0);
    idle();
    chk("mis_P_PC", bus.P_PC, 32'h1000);
    chk("mis_flag", 32'(bus.MISALIGN), 32'd1);
    drv(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    idle();
    chk("wrap_top", bus.P_PC, 32'hFFFF_FFFC);
    drv(0, 0, 0, 1, 32'h50, 0, 0);
    chk("wrap_zero", bus.P_PC, 32'h0);
    chk("wrap_CNT", bus.ISSUE_CNT, 32'd8);
    chk("mis_sticky", 32'(bus.MISALIGN), 32'd1);

    drv(0, 0, 0, 0, 32'h0, 1, 0);
    chk("halt_P_PC", bus.P_PC, 32'h50);
    for (int i = 0; i < 2; i++) begin
      idle();
      chk("halt_P_VALID", 32'(bus.P_VALID), 32'd0);
      chk("halt_HALTED", 32'(bus.HALTED), 32'd1);
      chk("halt_hold", bus.P_PC, 32'h50);
    end
    drv(0, 0, 0, 0, 32'h0, 0, 1);
    idle();
    chk("resume_valid", 32'(bus.P_VALID), 32'd1);
    chk("resume_pc", bus.P_PC, 32'h50);
    idle();
    chk("resume_next", bus.P_PC, 32'h54);
    chk("resume_cnt", bus.ISSUE_CNT, 32'd9);

    mw_left  = 0;
    rst_left = 0;
    for (int c = 0; c < 4000; c++) begin
      bit          r, st, mw, br, hr, rs;
      logic [31:0] bpc;
      if (rst_left > 0) rst_left--;
      else if ($urandom_range(0, 399) == 0) rst_left = $urandom_range(1, 3);
      r = (rst_left > 0);
      if (mw_left > 0) mw_left--;
      else if ($urandom_range(0, 7) == 0) mw_left = $urandom_range(1, 12);
      mw  = (mw_left > 0);
      st  = ($urandom_range(0, 3) == 0);
      br  = ($urandom_range(0, 6) == 0);
      bpc = $urandom;
      if ($urandom_range(0, 7) != 0) bpc[1:0] = 2'b00;
      if ($urandom_range(0, 15) == 0) bpc = 32'hFFFF_FFF8;
      hr  = ($urandom_range(0, 29) == 0);
      rs  = ($urandom_range(0, 9) == 0);
      drv(r, st, mw, br, bpc, hr, rs);
    end
    idle();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_pc_gen.md
Name: inst_pc_gen

Overview:
- Program-counter generation stage directly upstream of the instruction fetch stage.
- Drives the fetch stage's P_PC/P_VALID inputs and its STALL/FLUSH controls.
- Sequences sequential PC advance, branch/jump redirects from execute, fetch page-miss waits (MEM_WAIT) and halt/resume.
- Keeps the PC frozen while fetch is loading a page. Fetch latches its loaded page from the current PC when the burst completes, so the PC must not move mid-load.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded at reset (bits [1:0] must be 0)
CNT_WIDTH, 32, width of issued-instruction counter

Ports:
CLK  input  1  clock
RST  input  1  reset, synchronous, active-high
STALL_IN  input  1  pipeline hazard stall from downstream control
MEM_WAIT  input  1  fetch page miss in progress (from fetch stage)
BRANCH_EN  input  1  redirect request from execute, one-cycle pulse
BRANCH_PC  input  32  redirect target
HALT_REQ  input  1  stop issuing (ebreak/ecall from execute), pulse
RESUME  input  1  leave halt, pulse
P_PC  output  32  PC presented to fetch
P_VALID  output  1  P_PC is a real fetch request
STALL  output  1  stall to fetch stage
FLUSH  output  1  flush to fetch stage
HALTED  output  1  high in S_HALT
MISALIGN  output  1  sticky: a redirect target had bits [1:0] != 0
ISSUE_CNT  output  CNT_WIDTH  number of PCs accepted by fetch

Behaviour:
Reset state:
- P_PC = RESET_PC, P_VALID = 0, STALL = 0, FLUSH = 0, HALTED = 0, MISALIGN = 0, ISSUE_CNT = 0.
- Pending-redirect register cleared.
- State = S_BOOT.

States:
- S_BOOT: P_VALID = 0 for exactly one cycle after RST falls -> S_RUN.
- S_RUN: P_VALID = 1. HALT_REQ -> S_HALT (takes effect next cycle; HALT_REQ is ignored while MEM_WAIT=1, when it is held as a pending-halt flag until MEM_WAIT=0).
- S_HALT: P_VALID = 0, HALTED = 1, PC held. RESUME -> S_RUN.
- A redirect applied in S_HALT updates P_PC but stays halted.

Derived signals:
- advance = state==S_RUN & P_VALID & !STALL_IN & !MEM_WAIT & !apply.
  On advance: P_PC <= P_PC + 4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0); ISSUE_CNT <= ISSUE_CNT + 1 (wraps).
- apply = (BRANCH_EN | pend_valid) & !MEM_WAIT.
  On apply: P_PC <= target; pend_valid <= 0.
  Target is BRANCH_PC if BRANCH_EN, else the pending register.
  Target bits [1:0] are forced to 0; if they were nonzero, MISALIGN <= 1, sticky until RST.
- FLUSH = apply, combinational, same cycle. It kills fetch's latched request and its next-cycle output.
- STALL = STALL_IN & !apply. The fetch stage prioritises STALL over FLUSH, so STALL must be low whenever FLUSH is high.

Redirect rules:
- Redirect during MEM_WAIT=1: BRANCH_PC captured into the pending register, pend_valid <= 1. P_PC and P_VALID are not changed and FLUSH = 0 while MEM_WAIT=1.
- A second BRANCH_EN while pending overwrites the pending target (latest wins).
- Redirect beats STALL_IN: applies even with STALL_IN=1.
- BRANCH_EN and HALT_REQ in the same cycle: redirect applied, then halt.
- BRANCH_EN and apply of an older pending target in the same cycle: BRANCH_EN target wins.
- RST mid-wait or mid-pending: everything returns to reset values immediately; the pending redirect is discarded.

Latency:
- Redirect with MEM_WAIT=0 -> new P_PC visible 1 cycle later.
- With MEM_WAIT high, the new P_PC is visible 1 cycle after the cycle in which MEM_WAIT falls.

Test Plan:
- Reset: RST high 2 cycles, RESET_PC=0x100 -> P_PC=0x100, P_VALID=0 one cycle after RST low, then P_PC 0x100, 0x104, 0x108; ISSUE_CNT counts 1, 2, 3.
- Hazard stall: STALL_IN=1 for 3 cycles at P_PC=0x20 -> P_PC holds 0x20, STALL=1, ISSUE_CNT frozen; resumes at 0x24.
- Redirect during stall: STALL_IN=1, BRANCH_EN with BRANCH_PC=0x400 -> same cycle FLUSH=1, STALL=0; next cycle P_PC=0x400.
- Redirect during page miss: MEM_WAIT=1 for 10 cycles; BRANCH_EN(0x800) at cycle 3 and BRANCH_EN(0xC00) at cycle 5 -> P_PC unchanged and FLUSH=0 throughout; in the cycle MEM_WAIT falls, FLUSH=1; next cycle P_PC=0xC00.
- Misaligned target and wrap: BRANCH_PC=0x1002 -> P_PC=0x1000, MISALIGN=1 stays set. Separately, P_PC=0xFFFF_FFFC advance -> 0x0.
- Halt/resume: HALT_REQ at P_PC=0x50 -> P_VALID=0, HALTED=1, P_PC=0x50 held. RESUME -> P_VALID=1 next cycle at 0x50.
